// File: rtl/light_driver.sv
// light_driver: lamp driver and safety monitor for the 2-bit traffic light code.
// Enforces red clearance, latches a fault on illegal sequences (flashing yellow).
// Optional BLINK_WATCHDOG_EN: fault when the blink timebase stops ticking.
module light_driver #(
    parameter int C_CLEAR    = 4,
    parameter int C_WDOG_CYC = 200000000
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       blink,
    input  logic [1:0] inLight,
    input  logic       inClear,
    output logic       outCarR,
    output logic       outCarY,
    output logic       outCarG,
    output logic       outPedWalk,
    output logic       outPedStop,
    output logic [1:0] outShown,
    output logic       outFault
);
    localparam int DW = $clog2(C_CLEAR + 1);
    localparam logic [DW-1:0] CLEAR = DW'(C_CLEAR);

    typedef enum logic {S_RUN, S_FAULT} state_t;

    state_t        state, state_n;
    logic [1:0]    shown, shown_n;
    logic [DW-1:0] dwell, dwell_n;
    logic          blink_d, flash, flash_n, tick, legal, wdog_trip, run_n;

    assign tick     = blink & ~blink_d;
    assign legal    = (shown == 2'b00 && (inLight == 2'b01 || inLight == 2'b11)) ||
                      (shown == 2'b01 && inLight == 2'b10) ||
                      (shown[1] && inLight == 2'b00);
    assign run_n    = (state_n == S_RUN);
    assign outShown = shown;
    assign outFault = (state == S_FAULT);

`ifdef BLINK_WATCHDOG_EN
    localparam int WW = $clog2(C_WDOG_CYC + 1);
    localparam logic [WW-1:0] WDOG = WW'(C_WDOG_CYC);
    logic [WW-1:0] wdog;

    assign wdog_trip = (wdog == WDOG);

    // count clk cycles since the last tick; parked at zero while faulted
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) wdog <= '0;
        else       wdog <= (tick || !run_n) ? '0 : wdog + 1'b1;
    end
`else
    assign wdog_trip = 1'b0;
`endif

    // next-state: accept legal codes once red has cleared, fault on anything illegal
    always_comb begin
        state_n = state;
        shown_n = shown;
        dwell_n = (tick && dwell != CLEAR) ? dwell + 1'b1 : dwell;
        flash_n = 1'b0;
        if (state == S_RUN) begin
            if (wdog_trip || (inLight != shown && !legal)) begin
                state_n = S_FAULT;
                shown_n = 2'b00;
                dwell_n = '0;
            end else if (legal && (shown != 2'b00 || dwell == CLEAR)) begin
                shown_n = inLight;
                dwell_n = '0;
            end
        end else begin
            shown_n = 2'b00;
            dwell_n = '0;
            flash_n = flash ^ tick;
            if (inClear && inLight == 2'b00) begin
                state_n = S_RUN;
                flash_n = 1'b0;
            end
        end
    end

    // state and lamp registers; lamps decoded from the next state so they track acceptance
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= S_RUN;
            shown      <= 2'b00;
            dwell      <= '0;
            blink_d    <= 1'b0;
            flash      <= 1'b0;
            outCarR    <= 1'b1;
            outCarY    <= 1'b0;
            outCarG    <= 1'b0;
            outPedWalk <= 1'b0;
            outPedStop <= 1'b1;
        end else begin
            state      <= state_n;
            shown      <= shown_n;
            dwell      <= dwell_n;
            blink_d    <= blink;
            flash      <= flash_n;
            outCarR    <= run_n && (shown_n == 2'b00 || shown_n == 2'b11);
            outCarY    <= run_n ? (shown_n == 2'b10) : flash_n;
            outCarG    <= run_n && shown_n == 2'b01;
            outPedWalk <= run_n && shown_n == 2'b11;
            outPedStop <= run_n && shown_n != 2'b11;
        end
    end

    lamp_safe: assert property (@(posedge clk) disable iff (!rstb)
        !(outCarG && outPedWalk) && $countones({outCarR, outCarY, outCarG}) <= 1 &&
        (outFault || ($onehot({outCarR, outCarY, outCarG}) && $onehot({outPedWalk, outPedStop}))));
endmodule

// File: tb/tb_light_driver.sv
// tb_light_driver: directed scenario bench for light_driver.
module tb_light_driver;
    logic       clk = 1'b0, rstb = 1'b0, blink = 1'b0, inClear = 1'b0;
    logic [1:0] inLight = 2'b00;
    logic       outCarR, outCarY, outCarG, outPedWalk, outPedStop, outFault;
    logic [1:0] outShown;
    logic [7:0] obs;
    int         n_tests = 0, n_fail = 0;

    // {CarR, CarY, CarG, PedWalk, PedStop, Fault, Shown[1:0]}
    localparam logic [7:0] RED    = 8'b1000_1000;
    localparam logic [7:0] GREEN  = 8'b0010_1001;
    localparam logic [7:0] YELLOW = 8'b0100_1010;
    localparam logic [7:0] WALK   = 8'b1001_0011;
    localparam logic [7:0] FLT0   = 8'b0000_0100;
    localparam logic [7:0] FLT1   = 8'b0100_0100;

    light_driver #(.C_CLEAR(4), .C_WDOG_CYC(50)) dut (
        .clk(clk), .rstb(rstb), .blink(blink), .inLight(inLight), .inClear(inClear),
        .outCarR(outCarR), .outCarY(outCarY), .outCarG(outCarG), .outPedWalk(outPedWalk),
        .outPedStop(outPedStop), .outShown(outShown), .outFault(outFault)
    );

    assign obs = {outCarR, outCarY, outCarG, outPedWalk, outPedStop, outFault, outShown};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        blink = 1'b1;
        step();
        blink = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        step();
        step();
        n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL reset obs=%b want=%b", obs, RED); end
        rstb = 1'b1;
    endtask

    // leave red for code: held through 3 ticks and the 4th tick edge, shown one clk later
    task automatic test_clearance(input logic [1:0] code, input logic [7:0] want);
        inLight = code;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL clearance_hold%0d obs=%b want=%b", i, obs, RED); end
        end
        blink = 1'b1;
        step();
        n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL clearance_edgeN obs=%b want=%b", obs, RED); end
        blink = 1'b0;
        step();
        n_tests++; if (obs !== want) begin n_fail++; $display("FAIL clearance_accept obs=%b want=%b", obs, want); end
    endtask

    task automatic test_sequence();
        inLight = 2'b10;
        step();
        n_tests++; if (obs !== YELLOW) begin n_fail++; $display("FAIL seq_yellow obs=%b want=%b", obs, YELLOW); end
        for (int i = 0; i < 10; i++) tick();
        n_tests++; if (obs !== YELLOW) begin n_fail++; $display("FAIL seq_yellow_hold obs=%b want=%b", obs, YELLOW); end
        inLight = 2'b00;
        step();
        n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL seq_red obs=%b want=%b", obs, RED); end
        test_clearance(2'b11, WALK);
    endtask

    task automatic test_async_reset();
        #2 rstb = 1'b0;
        #1;
        n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL async_reset obs=%b want=%b", obs, RED); end
        step();
        inLight = 2'b01;
        rstb = 1'b1;
        test_clearance(2'b01, GREEN);
    endtask

    task automatic test_fault();
        inLight = 2'b11;
        step();
        n_tests++; if (obs !== FLT0) begin n_fail++; $display("FAIL fault_entry obs=%b want=%b", obs, FLT0); end
        blink = 1'b1;
        step();
        n_tests++; if (obs !== FLT1) begin n_fail++; $display("FAIL flash_on obs=%b want=%b", obs, FLT1); end
        blink = 1'b0;
        step();
        n_tests++; if (obs !== FLT1) begin n_fail++; $display("FAIL flash_hold obs=%b want=%b", obs, FLT1); end
        tick();
        n_tests++; if (obs !== FLT0) begin n_fail++; $display("FAIL flash_off obs=%b want=%b", obs, FLT0); end
    endtask

    task automatic test_clear();
        inClear = 1'b1;
        inLight = 2'b01;
        step();
        n_tests++; if (obs !== FLT0) begin n_fail++; $display("FAIL clear_wrong_code obs=%b want=%b", obs, FLT0); end
        inLight = 2'b00;
        step();
        n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL clear_exit obs=%b want=%b", obs, RED); end
        inClear = 1'b0;
        test_clearance(2'b01, GREEN);
    endtask

    task automatic test_pending_illegal();
        inLight = 2'b10;
        step();
        inLight = 2'b00;
        step();
        inLight = 2'b01;
        tick();
        n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL pending_hold obs=%b want=%b", obs, RED); end
        inLight = 2'b10;
        step();
        n_tests++; if (obs !== FLT0) begin n_fail++; $display("FAIL pending_illegal obs=%b want=%b", obs, FLT0); end
        inClear = 1'b1;
        inLight = 2'b00;
        step();
        inClear = 1'b0;
        n_tests++; if (obs !== RED) begin n_fail++; $display("FAIL pending_clear obs=%b want=%b", obs, RED); end
    endtask

    task automatic test_watchdog();
        logic [7:0] want;
`ifdef BLINK_WATCHDOG_EN
        want = FLT0;
`else
        want = RED;
`endif
        blink = 1'b0;
        for (int i = 0; i < 60; i++) step();
        n_tests++; if (obs !== want) begin n_fail++; $display("FAIL watchdog obs=%b want=%b", obs, want); end
    endtask

    initial begin
        test_reset();
        test_clearance(2'b01, GREEN);
        test_sequence();
        test_async_reset();
        test_fault();
        test_clear();
        test_pending_illegal();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
